// File: rtl/seg_scan_reader.sv
// seg_scan_reader
// Recovers the hex digits shown on a multiplexed 4-digit, 7-segment display.
// The reader watches the digit-select and segment lines and waits for each
// digit selection to settle before it takes one sample per visit. A value is
// accepted only after it has been seen on several consecutive visits of the
// same digit.
module seg_scan_reader #(
    parameter int SETTLE = 4,   // clocks to wait after a digit-select change (0..15)
    parameter int STABLE = 3    // identical samples required before commit (1..3)
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [3:0]  DIG,
    input  logic [6:0]  SEG,
    output logic [15:0] HEX,
    output logic [3:0]  VALID,
    output logic        UPD,
    output logic        BAD
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);
    localparam logic [1:0] STABLE_MIN  = 2'(STABLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } state_t;

    // With no settle time a new selection goes straight to sampling.
    localparam state_t START_STATE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic [3:0] dig_q;
    logic [3:0] dig_last;   // dig_q one clock earlier, for change detection
    logic [6:0] seg_q;

    // Register the display lines once; everything downstream uses dig_q/seg_q.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            dig_q    <= '0;
            dig_last <= '0;
            seg_q    <= '0;
        end else begin
            dig_q    <= DIG;
            dig_last <= dig_q;
            seg_q    <= SEG;
        end
    end

    logic       dig_onehot;
    logic       dig_change;
    logic [1:0] dig_idx;

    assign dig_onehot = (dig_q != 4'd0) && ((dig_q & (dig_q - 4'd1)) == 4'd0);
    assign dig_change = (dig_q != dig_last);

    // Encode the selected digit; only meaningful when dig_onehot is set.
    always_comb begin
        dig_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (dig_q[i]) begin
                dig_idx = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-tracking state machine
    // ------------------------------------------------------------------
    state_t     state;
    logic [3:0] settle_cnt;
    logic [1:0] sel;        // digit latched when the current visit started
    logic       restart;
    logic       to_idle;
    logic       sample_fire;

    // A new legal selection (re)starts the settle wait from any state; in
    // IDLE any one-hot value counts, since IDLE is only entered on a non-one-hot one.
    assign restart = (state == S_IDLE) ? dig_onehot : (dig_change && dig_onehot);
    assign to_idle = (state != S_IDLE) && dig_change && !dig_onehot;

    // A selection change during the sample clock means seg_q already belongs
    // to the next digit, so that sample is dropped.
    assign sample_fire = (state == S_SAMPLE) && !dig_change;

    // Track visits: settle, take exactly one sample, then hold until DIG changes.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            sel        <= '0;
        end else if (restart) begin
            state      <= START_STATE;
            settle_cnt <= SETTLE_LOAD;
            sel        <= dig_idx;
        end else if (to_idle) begin
            state      <= S_IDLE;
        end else begin
            case (state)
                S_SETTLE: begin
                    if (settle_cnt <= 4'd1) begin
                        settle_cnt <= '0;
                        state      <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_SAMPLE: state <= S_HOLD;
                default:  state <= state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Segment decode
    // ------------------------------------------------------------------
    // Result layout: {legal, blank, nibble}.
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h7E:   return {2'b10, 4'h0};
            7'h30:   return {2'b10, 4'h1};
            7'h6D:   return {2'b10, 4'h2};
            7'h79:   return {2'b10, 4'h3};
            7'h33:   return {2'b10, 4'h4};
            7'h5B:   return {2'b10, 4'h5};
            7'h5F:   return {2'b10, 4'h6};
            7'h70:   return {2'b10, 4'h7};
            7'h7F:   return {2'b10, 4'h8};
            7'h7B:   return {2'b10, 4'h9};
            7'h77:   return {2'b10, 4'hA};
            7'h1F:   return {2'b10, 4'hB};
            7'h4E:   return {2'b10, 4'hC};
            7'h3D:   return {2'b10, 4'hD};
            7'h4F:   return {2'b10, 4'hE};
            7'h47:   return {2'b10, 4'hF};
            7'h00:   return {2'b11, 4'h0};
            default: return {2'b00, 4'h0};
        endcase
    endfunction

    logic       dec_legal;
    logic       dec_blank;
    logic [3:0] dec_nib;

    assign {dec_legal, dec_blank, dec_nib} = seg_decode(seg_q);

    // ------------------------------------------------------------------
    // Per-digit candidate / commit logic
    // ------------------------------------------------------------------
    logic [3:0] chg;    // per digit: committed nibble or valid bit is about to change

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic       hit;
            logic       cand_blank;
            logic [3:0] cand_nib;
            logic [1:0] cand_cnt;
            logic [3:0] nib_q;
            logic       valid_q;

            logic       cand_blank_next;
            logic [3:0] cand_nib_next;
            logic [1:0] cnt_next;
            logic [1:0] cnt_inc;
            logic [3:0] nib_next;
            logic       valid_next;

            assign hit = sample_fire && (sel == 2'(gi));

            // Fold one sample into this digit's candidate and decide on a commit.
            always_comb begin
                cand_blank_next = cand_blank;
                cand_nib_next   = cand_nib;
                cnt_next        = cand_cnt;
                nib_next        = nib_q;
                valid_next      = valid_q;
                cnt_inc         = (cand_cnt == 2'd3) ? 2'd3 : cand_cnt + 2'd1;
                if (hit) begin
                    if (!dec_legal) begin
                        // Garbage on the lines breaks the run but keeps the candidate.
                        cnt_next = 2'd0;
                    end else begin
                        if ((dec_blank == cand_blank) &&
                            (dec_blank || (dec_nib == cand_nib))) begin
                            cnt_next = cnt_inc;
                        end else begin
                            cand_blank_next = dec_blank;
                            cand_nib_next   = dec_nib;
                            cnt_next        = 2'd1;
                        end
                        if (cnt_next >= STABLE_MIN) begin
                            if (dec_blank) begin
                                // A blank digit keeps its last nibble for reference.
                                valid_next = 1'b0;
                            end else begin
                                valid_next = 1'b1;
                                nib_next   = dec_nib;
                            end
                        end
                    end
                end
            end

            // Hold this digit's candidate, run count and committed value.
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    cand_blank <= 1'b1;
                    cand_nib   <= '0;
                    cand_cnt   <= '0;
                    nib_q      <= '0;
                    valid_q    <= 1'b0;
                end else begin
                    cand_blank <= cand_blank_next;
                    cand_nib   <= cand_nib_next;
                    cand_cnt   <= cnt_next;
                    nib_q      <= nib_next;
                    valid_q    <= valid_next;
                end
            end

            assign chg[gi]        = (nib_next != nib_q) || (valid_next != valid_q);
            assign HEX[4*gi +: 4] = nib_q;
            assign VALID[gi]      = valid_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Event pulses, aligned with the clock on which HEX/VALID change
    // ------------------------------------------------------------------
    // UPD only for real changes; BAD for every illegal sample.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            UPD <= 1'b0;
            BAD <= 1'b0;
        end else begin
            UPD <= |chg;
            BAD <= sample_fire && !dec_legal;
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader
// Directed scan sequences against a visit-level model of the reader: the model
// tracks runs of constant digit selection at the pins and applies the
// candidate / commit rules per digit. Outputs are compared every cycle, and
// literal expectations pin the headline results of each scenario.
module tb_seg_scan_reader;

    localparam int S  = 4;
    localparam int ST = 3;

    logic        CLK    = 1'b0;
    logic        RESETN = 1'b1;
    logic [3:0]  DIG    = 4'b0000;
    logic [6:0]  SEG    = 7'h00;
    logic [15:0] HEX;
    logic [3:0]  VALID;
    logic        UPD;
    logic        BAD;

    seg_scan_reader #(.SETTLE(S), .STABLE(ST)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .DIG    (DIG),
        .SEG    (SEG),
        .HEX    (HEX),
        .VALID  (VALID),
        .UPD    (UPD),
        .BAD    (BAD)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_seen = 0;
    int bad_seen = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          m_cand [4];   // 0..15 digit, 16 blank
    int          m_cnt  [4];
    logic [15:0] m_hex;
    logic [3:0]  m_valid;
    logic        m_upd;
    logic        m_bad;
    logic [3:0]  run_val;      // DIG value of the current run of clock edges
    int          run_len;      // edges in that run so far
    logic [6:0]  seg_last;     // SEG seen at the previous edge

    function automatic int decode(input logic [6:0] s);
        case (s)
            7'h7E: return 0;   7'h30: return 1;   7'h6D: return 2;   7'h79: return 3;
            7'h33: return 4;   7'h5B: return 5;   7'h5F: return 6;   7'h70: return 7;
            7'h7F: return 8;   7'h7B: return 9;   7'h77: return 10;  7'h1F: return 11;
            7'h4E: return 12;  7'h3D: return 13;  7'h4F: return 14;  7'h47: return 15;
            7'h00: return 16;
            default: return -1;
        endcase
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cand[i] = 16;
            m_cnt[i]  = 0;
        end
        m_hex    = 16'h0000;
        m_valid  = 4'b0000;
        m_upd    = 1'b0;
        m_bad    = 1'b0;
        run_val  = 4'b0000;
        run_len  = 1;
        seg_last = 7'h00;
    endtask

    task automatic apply_sample(input int d, input logic [6:0] s);
        int          code;
        logic [15:0] old_hex;
        logic [3:0]  old_valid;
        code = decode(s);
        if (code < 0) begin
            m_bad    = 1'b1;
            m_cnt[d] = 0;
            return;
        end
        if (code == m_cand[d]) m_cnt[d] = (m_cnt[d] < 3) ? m_cnt[d] + 1 : 3;
        else begin
            m_cand[d] = code;
            m_cnt[d]  = 1;
        end
        if (m_cnt[d] >= ST) begin
            old_hex   = m_hex;
            old_valid = m_valid;
            if (code == 16) m_valid[d] = 1'b0;
            else begin
                m_valid[d]       = 1'b1;
                m_hex[4*d +: 4]  = code[3:0];
            end
            if (m_hex != old_hex || m_valid != old_valid) m_upd = 1'b1;
        end
    endtask

    // One rising edge: a visit whose selection has been constant for S+2 edges
    // yields one sample of SEG as seen on the last of those edges.
    task automatic model_edge();
        m_upd = 1'b0;
        m_bad = 1'b0;
        if (!RESETN) begin
            model_reset();
            return;
        end
        if ($countones(run_val) == 1 && run_len == S + 2)
            apply_sample(idx_of(run_val), seg_last);
        if (DIG == run_val) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_val = DIG;
            run_len = 1;
        end
        seg_last = SEG;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge CLK) begin
        if (cmp_on) begin
            check("hex",   {16'h0, HEX},   {16'h0, m_hex});
            check("valid", {28'h0, VALID}, {28'h0, m_valid});
            check("upd",   {31'h0, UPD},   {31'h0, m_upd});
            check("bad",   {31'h0, BAD},   {31'h0, m_bad});
            if (UPD === 1'b1) upd_seen++;
            if (BAD === 1'b1) bad_seen++;
        end
    end

    task automatic do_reset();
        RESETN = 1'b0;
        model_reset();
        DIG = 4'b0000;
        SEG = 7'h00;
        repeat (2) tick();
        RESETN = 1'b1;
        repeat (2) tick();
    endtask

    task automatic visit(input logic [3:0] d, input logic [6:0] s, input int gap);
        DIG = d;
        SEG = s;
        repeat (10) tick();
        if (gap > 0) begin
            DIG = 4'b0000;
            SEG = 7'h00;
            repeat (gap) tick();
        end
        $display("visit dig=%b seg=%h -> hex=%h valid=%b upd_total=%0d bad_total=%0d",
                 d, s, HEX, VALID, upd_seen, bad_seen);
    endtask

    task automatic scan_round();
        visit(4'b0001, 7'h7E, 0);
        visit(4'b0010, 7'h30, 0);
        visit(4'b0100, 7'h6D, 0);
        visit(4'b1000, 7'h47, 0);
    endtask

    int base_upd;
    int base_bad;

    initial begin
        #1;
        RESETN = 1'b0;
        model_reset();
        cmp_on = 1'b1;
        repeat (3) tick();
        check("rst_hex",   {16'h0, HEX},   32'h0);
        check("rst_valid", {28'h0, VALID}, 32'h0);
        check("rst_upd",   {31'h0, UPD},   32'h0);
        check("rst_bad",   {31'h0, BAD},   32'h0);
        RESETN = 1'b1;
        repeat (2) tick();

        // Single digit, three visits of "3".
        base_upd = upd_seen;
        for (int v = 0; v < 3; v++) visit(4'b0001, 7'h79, 2);
        check("r029_hex",   {16'h0, HEX},   32'h0003);
        check("r029_valid", {28'h0, VALID}, 32'h1);
        check("r029_upd",   upd_seen - base_upd, 1);

        // Full scan of all four digits.
        do_reset();
        base_upd = upd_seen;
        for (int r = 0; r < 3; r++) scan_round();
        check("r030_hex",   {16'h0, HEX},   32'hF210);
        check("r030_valid", {28'h0, VALID}, 32'hF);
        check("r030_upd",   upd_seen - base_upd, 4);
        base_upd = upd_seen;
        for (int r = 0; r < 2; r++) scan_round();
        check("r030_quiet", upd_seen - base_upd, 0);

        // Short glitch of another value must not commit.
        do_reset();
        base_upd = upd_seen;
        for (int v = 0; v < 3; v++) visit(4'b0010, 7'h5B, 2);
        check("r031_first", {16'h0, HEX}, 32'h0050);
        base_upd = upd_seen;
        for (int v = 0; v < 2; v++) visit(4'b0010, 7'h7F, 2);
        for (int v = 0; v < 3; v++) visit(4'b0010, 7'h5B, 2);
        check("r031_keep",     {16'h0, HEX}, 32'h0050);
        check("r031_keep_upd", upd_seen - base_upd, 0);
        base_upd = upd_seen;
        for (int v = 0; v < 3; v++) visit(4'b0010, 7'h7F, 2);
        check("r031_new",     {16'h0, HEX}, 32'h0080);
        check("r031_new_upd", upd_seen - base_upd, 1);

        // Illegal pattern, then blank.
        do_reset();
        for (int v = 0; v < 3; v++) visit(4'b0100, 7'h6D, 2);
        base_upd = upd_seen;
        base_bad = bad_seen;
        for (int v = 0; v < 2; v++) visit(4'b0100, 7'h01, 2);
        check("r032_bad",       bad_seen - base_bad, 2);
        check("r032_bad_valid", {28'h0, VALID}, 32'h4);
        check("r032_bad_upd",   upd_seen - base_upd, 0);
        base_upd = upd_seen;
        for (int v = 0; v < 3; v++) visit(4'b0100, 7'h00, 2);
        check("r032_blank_valid", {28'h0, VALID}, 32'h0);
        check("r032_blank_hex",   {16'h0, HEX},   32'h0200);
        check("r032_blank_upd",   upd_seen - base_upd, 1);

        // Illegal / too-fast selections produce nothing.
        do_reset();
        base_upd = upd_seen;
        base_bad = bad_seen;
        DIG = 4'b0011;
        SEG = 7'h30;
        repeat (20) tick();
        for (int k = 0; k < 10; k++) begin
            DIG = 4'b0001; repeat (2) tick();
            DIG = 4'b0010; repeat (2) tick();
        end
        $display("glitch scan -> hex=%h valid=%b", HEX, VALID);
        check("r033_upd",   upd_seen - base_upd, 0);
        check("r033_bad",   bad_seen - base_bad, 0);
        check("r033_valid", {28'h0, VALID}, 32'h0);
        for (int v = 0; v < 3; v++) visit(4'b0100, 7'h30, 2);
        check("r033_after", {16'h0, HEX},   32'h0100);
        check("r033_avld",  {28'h0, VALID}, 32'h4);

        // Reset in the middle of a settle wait.
        do_reset();
        for (int r = 0; r < 3; r++) scan_round();
        check("r034_pre", {28'h0, VALID}, 32'hF);
        DIG = 4'b0010;
        SEG = 7'h30;
        repeat (2) tick();
        #2;
        RESETN = 1'b0;
        model_reset();
        #1;
        check("r034_hex",   {16'h0, HEX},   32'h0);
        check("r034_valid", {28'h0, VALID}, 32'h0);
        check("r034_upd",   {31'h0, UPD},   32'h0);
        check("r034_bad",   {31'h0, BAD},   32'h0);
        repeat (2) tick();
        RESETN = 1'b1;
        base_upd = upd_seen;
        base_bad = bad_seen;
        for (int v = 0; v < 2; v++) visit(4'b0010, 7'h30, 2);
        check("r034_quiet_upd", upd_seen - base_upd, 0);
        check("r034_quiet_bad", bad_seen - base_bad, 0);
        visit(4'b0010, 7'h30, 2);
        check("r034_fresh_upd", upd_seen - base_upd, 1);
        check("r034_fresh_hex", {16'h0, HEX}, 32'h0010);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
